sha_digest_serializer: RTL and testbench
========================================

SHA_DIGEST_SERIALIZER -- requirements
Module: sha_digest_serializer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for a 256-bit digest source.
REQ-002 rstn  input  1  asynchronous active-low reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 ivalid  input  1  one-cycle digest-valid pulse from upstream hash core; no backpressure exists on this side.
REQ-005 iid  input  32  message id accompanying ivalid.
REQ-006 ilen  input  61  message length in bytes accompanying ivalid.
REQ-007 isha  input  256  digest accompanying ivalid, bit 255 = first digest byte MSB.
REQ-008 oready  input  1  downstream ready.
REQ-009 ovalid  output  1  output word valid.
REQ-010 odata  output  32  output word.
REQ-011 olast  output  1  marks final word of a frame.
REQ-012 odrop  output  1  one-cycle pulse: an incoming digest was discarded.
REQ-013 odrop_cnt  output  16  count of discarded digests.

Function
REQ-014 Each captured digest SHALL be emitted as one 11-word frame: W0 = iid; W1 = {3'b0, ilen[60:32]}; W2 = ilen[31:0]; W3..W10 = isha[255:224] down to isha[31:0]; olast=1 only on W10.
REQ-015 Storage SHALL be a 2-entry FIFO of {iid, ilen, isha}; frames are emitted strictly in arrival order.
REQ-016 A digest with ivalid=1 SHALL be captured when FIFO count < 2, or when count == 2 and W10 handshakes (ovalid & oready & olast) in the same cycle.
REQ-017 Otherwise the digest SHALL be discarded: odrop=1 on the next cycle, odrop_cnt += 1, saturating at 16'hFFFF.
REQ-018 A word transfer occurs only on ovalid & oready; odata/olast/ovalid SHALL hold stable while ovalid & ~oready.
REQ-019 ovalid SHALL be 1 whenever FIFO count >= 1; odata, ovalid and olast SHALL be driven from registers or from FIFO storage plus a registered word index, with no combinational path from ivalid or oready to any output.
REQ-020 Latency: digest captured at edge N into an empty FIFO -> ovalid=1 with W0 on odata after edge N.
REQ-021 Word index SHALL run 0..10; on W10 handshake it returns to 0 and the head entry is popped.
REQ-022 If a second entry is present, its W0 SHALL be presented in the cycle immediately after W10 is accepted (no bubble).
REQ-023 Simultaneous capture and pop SHALL leave count unchanged and keep both the new entry and the next head intact.
REQ-024 oready toggling mid-frame SHALL only stall; it never reorders, repeats or skips words.
REQ-025 odrop SHALL be 0 in every cycle not following a discard.

Reset
REQ-026 While rstn=0: ovalid=0, olast=0, odata=0, odrop=0, odrop_cnt=0, FIFO count=0, word index=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame and discard both entries; after release, the next ivalid produces a fresh frame starting at W0.
REQ-028 ivalid in the first edge after rstn release SHALL be captured normally.

Verification
REQ-029 Single digest, oready=1: iid=32'h111, ilen=61'd3, isha=SHA-256("abc") -> 11 consecutive words ending with odata=32'hf20015ad and olast=1; W1=0; W2=3.
REQ-030 Backpressure: oready random 50% during a frame -> the 11-word sequence matches REQ-029 exactly, and odata holds stable on every stalled cycle.
REQ-031 Three digests (ids 222, 333, 444) in consecutive cycles with oready=0 -> 222 and 333 are emitted later in that order; 444 is dropped, odrop pulses once, and odrop_cnt=1.
REQ-032 FIFO full with a digest arriving in the same cycle as the W10 handshake -> no drop, and the new frame follows the queued frame.
REQ-033 ilen=61'h1FFF_FFFF_FFFF_FFFF -> W1=32'h1FFFFFFF and W2=32'hFFFFFFFF.
REQ-034 rstn pulsed low at W5 with 2 entries queued -> ovalid=0 immediately; after release, a new digest emits W0 with its own id and odrop_cnt=0.

Source files
------------

// File: rtl/sha_digest_serializer.sv
// Serializes captured 256-bit digests with id and length into 11-word frames.
// Two-entry FIFO in front; digests arriving while it stays full are counted as drops.
module sha_digest_serializer (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ivalid,
    input  logic [31:0]  iid,
    input  logic [60:0]  ilen,
    input  logic [255:0] isha,
    input  logic         oready,
    output logic         ovalid,
    output logic [31:0]  odata,
    output logic         olast,
    output logic         odrop,
    output logic [15:0]  odrop_cnt
);

    typedef struct packed {
        logic [31:0]  id;
        logic [60:0]  len;
        logic [255:0] sha;
    } entry_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    entry_t     mem [2];
    entry_t     cur;
    logic       head;
    logic [1:0] count;
    logic [3:0] widx;
    logic       pop;
    logic       push;
    logic       wr;
    logic [8:0] shamt;
    logic [255:0] sha_sh;

    assign cur = mem[head];
    assign ovalid = (count != 2'd0);
    assign olast = ovalid & (widx == LAST_IDX);
    assign pop = ovalid & oready & (widx == LAST_IDX);
    // A full FIFO can still accept when its head leaves in the same cycle.
    assign push = ivalid & ((count != 2'd2) | pop);
    // With count 2 the write lands in the slot being popped.
    assign wr = head ^ count[0];

    assign shamt = {LAST_IDX - widx, 5'b0};
    assign sha_sh = cur.sha >> shamt;

    always_comb begin
        odata = '0;
        if (ovalid) begin
            case (widx)
                4'd0:    odata = cur.id;
                4'd1:    odata = {3'b000, cur.len[60:32]};
                4'd2:    odata = cur.len[31:0];
                default: odata = (widx <= LAST_IDX) ? sha_sh[31:0] : 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr] <= '{id: iid, len: ilen, sha: isha};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head      <= 1'b0;
            count     <= 2'd0;
            widx      <= 4'd0;
            odrop     <= 1'b0;
            odrop_cnt <= 16'd0;
        end else begin
            if (ovalid && oready) begin
                widx <= pop ? 4'd0 : widx + 4'd1;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            odrop <= ivalid & ~push;
            if (ivalid && !push && odrop_cnt != 16'hFFFF) begin
                odrop_cnt <= odrop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha_digest_serializer.sv
// Bench for sha_digest_serializer: directed scenarios plus random traffic
// checked against a frame-queue reference model.
module tb_sha_digest_serializer;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         ivalid = 1'b0;
    logic [31:0]  iid = '0;
    logic [60:0]  ilen = '0;
    logic [255:0] isha = '0;
    logic         oready = 1'b0;
    logic         ovalid;
    logic [31:0]  odata;
    logic         olast;
    logic         odrop;
    logic [15:0]  odrop_cnt;

    sha_digest_serializer dut (
        .clk(clk), .rstn(rstn), .ivalid(ivalid), .iid(iid),
        .ilen(ilen), .isha(isha), .oready(oready), .ovalid(ovalid),
        .odata(odata), .olast(olast), .odrop(odrop),
        .odrop_cnt(odrop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  id;
        logic [60:0]  len;
        logic [255:0] sha;
    } frame_t;

    frame_t      q[$];
    logic [31:0] got[$];
    int          pos;
    bit          exp_drop;
    int          exp_cnt;
    int          drops_seen;
    int          errors;
    int          checks;
    bit          prev_stall;
    logic [31:0] prev_data;
    frame_t      zf;
    frame_t      abc;

    function automatic logic [31:0] word_of(frame_t f, int w);
        logic [351:0] v;
        v = {f.id, 3'b000, f.len, f.sha};
        return v[351 - 32*w -: 32];
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f.id = $urandom;
        f.len = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) f.sha[32*i +: 32] = $urandom;
        return f;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit iv, input frame_t f, input bit rdy);
        bit exp_v, hs, popped, cap;
        int sz;
        @(negedge clk);
        rstn = 1'b1;
        ivalid = iv;
        iid = f.id;
        ilen = f.len;
        isha = f.sha;
        oready = rdy;
        #1;
        exp_v = (q.size() > 0);
        check("ovalid", {63'd0, ovalid}, {63'd0, exp_v});
        if (exp_v) begin
            check("odata", {32'd0, odata}, {32'd0, word_of(q[0], pos)});
            check("olast", {63'd0, olast}, {63'd0, pos == 10});
        end
        if (prev_stall) check("hold", {32'd0, odata}, {32'd0, prev_data});
        check("odrop", {63'd0, odrop}, {63'd0, exp_drop});
        check("odrop_cnt", {48'd0, odrop_cnt}, 64'(exp_cnt));
        if (odrop) drops_seen++;
        prev_stall = exp_v && !rdy;
        prev_data = odata;
        if (exp_v && rdy) got.push_back(odata);
        sz = q.size();
        hs = exp_v && rdy;
        popped = 1'b0;
        if (hs) begin
            if (pos == 10) begin
                void'(q.pop_front());
                pos = 0;
                popped = 1'b1;
            end else begin
                pos++;
            end
        end
        cap = iv && (sz < 2 || popped);
        if (cap) q.push_back(f);
        exp_drop = iv && !cap;
        if (exp_drop && exp_cnt < 65535) exp_cnt++;
    endtask

    task automatic model_reset();
        q.delete();
        pos = 0;
        exp_drop = 1'b0;
        exp_cnt = 0;
        prev_stall = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ovalid"}, {63'd0, ovalid}, 64'd0);
        check({tag, "_olast"}, {63'd0, olast}, 64'd0);
        check({tag, "_odata"}, {32'd0, odata}, 64'd0);
        check({tag, "_odrop"}, {63'd0, odrop}, 64'd0);
        check({tag, "_cnt"}, {48'd0, odrop_cnt}, 64'd0);
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            cycle(1'b0, zf, rnd ? 1'($urandom_range(1)) : 1'b1);
            n++;
        end
        check("drain_bound", {63'd0, n < 400}, 64'd1);
    endtask

    task automatic run_to_pos(input int p);
        int n;
        n = 0;
        while (pos != p && n < 40) begin
            cycle(1'b0, zf, 1'b1);
            n++;
        end
        check("pos_bound", {63'd0, n < 40}, 64'd1);
    endtask

    initial begin
        frame_t fa, fb, fc;
        errors = 0;
        checks = 0;
        drops_seen = 0;
        zf = '{id: '0, len: '0, sha: '0};
        abc.id = 32'h111;
        abc.len = 61'd3;
        abc.sha = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
        model_reset();

        // Reset state
        #12;
        reset_checks("rst");

        // Single digest, continuous ready
        got.delete();
        cycle(1'b1, abc, 1'b1);
        drain(1'b0);
        check("abc_len", 64'(got.size()), 64'd11);
        if (got.size() == 11) begin
            check("abc_w0", {32'd0, got[0]}, 64'h111);
            check("abc_w1", {32'd0, got[1]}, 64'd0);
            check("abc_w2", {32'd0, got[2]}, 64'd3);
            check("abc_w10", {32'd0, got[10]}, 64'hf20015ad);
        end

        // Same digest under random backpressure
        got.delete();
        cycle(1'b1, abc, 1'($urandom_range(1)));
        drain(1'b1);
        check("bp_len", 64'(got.size()), 64'd11);
        if (got.size() == 11) begin
            check("bp_w3", {32'd0, got[3]}, 64'hba7816bf);
            check("bp_w10", {32'd0, got[10]}, 64'hf20015ad);
        end

        // Three back-to-back digests while stalled: third is dropped
        got.delete();
        drops_seen = 0;
        fa = rand_frame(); fa.id = 32'd222;
        fb = rand_frame(); fb.id = 32'd333;
        fc = rand_frame(); fc.id = 32'd444;
        cycle(1'b1, fa, 1'b0);
        cycle(1'b1, fb, 1'b0);
        cycle(1'b1, fc, 1'b0);
        cycle(1'b0, zf, 1'b0);
        cycle(1'b0, zf, 1'b0);
        check("drop_cnt", {48'd0, odrop_cnt}, 64'd1);
        drain(1'b0);
        check("drop_pulses", 64'(drops_seen), 64'd1);
        check("drop_len", 64'(got.size()), 64'd22);
        if (got.size() == 22) begin
            check("ord_222", {32'd0, got[0]}, 64'd222);
            check("ord_333", {32'd0, got[11]}, 64'd333);
        end

        // Arrival while full, coinciding with the W10 handshake
        got.delete();
        fa = rand_frame();
        fb = rand_frame();
        fc = rand_frame();
        cycle(1'b1, fa, 1'b0);
        cycle(1'b1, fb, 1'b1);
        run_to_pos(10);
        cycle(1'b1, fc, 1'b1);
        cycle(1'b0, zf, 1'b1);
        check("full_nodrop", {48'd0, odrop_cnt}, 64'd1);
        drain(1'b0);
        check("full_len", 64'(got.size()), 64'd33);
        if (got.size() == 33) begin
            check("full_b", {32'd0, got[11]}, {32'd0, fb.id});
            check("full_c", {32'd0, got[22]}, {32'd0, fc.id});
        end

        // Maximum length
        got.delete();
        fa = rand_frame();
        fa.len = 61'h1FFF_FFFF_FFFF_FFFF;
        cycle(1'b1, fa, 1'b1);
        drain(1'b0);
        if (got.size() == 11) begin
            check("maxlen_w1", {32'd0, got[1]}, 64'h1FFFFFFF);
            check("maxlen_w2", {32'd0, got[2]}, 64'hFFFFFFFF);
        end else begin
            check("maxlen_len", 64'(got.size()), 64'd11);
        end

        // Reset mid-frame with two entries queued
        fa = rand_frame();
        fb = rand_frame();
        cycle(1'b1, fa, 1'b0);
        cycle(1'b1, fb, 1'b0);
        run_to_pos(5);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        reset_checks("midrst");
        got.delete();
        fc = rand_frame();
        cycle(1'b1, fc, 1'b1);
        drain(1'b0);
        check("post_rst_len", 64'(got.size()), 64'd11);
        if (got.size() == 11) check("post_rst_id", {32'd0, got[0]}, {32'd0, fc.id});
        check("post_rst_cnt", {48'd0, odrop_cnt}, 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(99) < 35, rand_frame(), 1'($urandom_range(1)));
        end
        drain(1'b1);
        cycle(1'b0, zf, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
